// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALU selects
// and the bundled control-strobe word. Honours MC_ILLEGAL_TRAP_EN (adds illegal flag).
package mc_pkg;

  localparam int unsigned OP_W_DEF = 4;
  localparam int unsigned ST_W_DEF = 4;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    EXEC_I   = 4'd4,
    WB_I     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    WB_MEM   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    HALT     = 4'd11
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_TWO     = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH1 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_MEM,
    CLS_BR,
    CLS_ILL
  } op_class_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

  function automatic op_class_e classify(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: classify = CLS_R;
      OP_ADDI:                               classify = CLS_I;
      OP_LW, OP_SW:                          classify = CLS_MEM;
      OP_BEQ:                                classify = CLS_BR;
      default:                               classify = CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Shared instruction/data memory port: request, write strobe, address select
// and the ready handshake returned by memory.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/mc_output_decode.sv
// Moore strobe decode from current state; mem_ready only gates the completion
// strobes of FETCH and MEM_WR. Honours MC_ILLEGAL_TRAP_EN.
module mc_output_decode
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic       mem_ready,
  input  logic [3:0] op,
  output ctrl_t      ctrl
);

`ifdef MC_ILLEGAL_TRAP_EN
  logic unused_op;
  assign unused_op = ^op;
`endif

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        // ALUOut captures the branch target speculatively
        ctrl.alu_src_b = SRCB_IMM_SH1;
        ctrl.alu_op    = ALUOP_ADD;
`ifndef MC_ILLEGAL_TRAP_EN
        ctrl.instr_done = (classify(op) == CLS_ILL);
`endif
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_we     = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      HALT: ctrl.illegal = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit MIPS-subset datapath: state register,
// next-state logic and reset gating of the decoded strobes. Honours MC_ILLEGAL_TRAP_EN.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEF,
  parameter int unsigned ST_W = ST_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic                zero,
  multicycle_control_if.master mem,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                instr_done,
  output logic [ST_W-1:0]     state
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic                illegal
`endif
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] opc;
  ctrl_t      dec;
  ctrl_t      ctrl;

  assign opc = 4'(op);

  // zero is consumed by the datapath through pc_write_cond, not by the sequencer
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (classify(opc))
          CLS_R:   state_d = EXEC_R;
          CLS_I:   state_d = EXEC_I;
          CLS_MEM: state_d = MEM_ADDR;
          CLS_BR:  state_d = BRANCH;
`ifdef MC_ILLEGAL_TRAP_EN
          default: state_d = HALT;
`else
          default: state_d = FETCH;
`endif
        endcase
      end
      EXEC_R:   state_d = WB_R;
      WB_R:     state_d = FETCH;
      EXEC_I:   state_d = WB_I;
      WB_I:     state_d = FETCH;
      MEM_ADDR: state_d = (opc == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = mem.mem_ready ? WB_MEM : MEM_RD;
      WB_MEM:   state_d = FETCH;
      MEM_WR:   state_d = mem.mem_ready ? FETCH : MEM_WR;
      BRANCH:   state_d = FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      HALT:     state_d = HALT;
`endif
      default:  state_d = FETCH;
    endcase
  end

  mc_output_decode u_dec (
    .state     (state_q),
    .mem_ready (mem.mem_ready),
    .op        (opc),
    .ctrl      (dec)
  );

  // Reset is sampled synchronously, yet strobes must already be quiet in the reset cycle
  always_comb begin
    ctrl = dec;
    if (reset) ctrl = '0;
  end

  assign mem.mem_req    = ctrl.mem_req;
  assign mem.mem_we     = ctrl.mem_we;
  assign mem.iord       = ctrl.iord;
  assign ir_write       = ctrl.ir_write;
  assign pc_write       = ctrl.pc_write;
  assign pc_write_cond  = ctrl.pc_write_cond;
  assign pc_source      = ctrl.pc_source;
  assign alu_src_a      = ctrl.alu_src_a;
  assign alu_src_b      = ctrl.alu_src_b;
  assign alu_op         = ctrl.alu_op;
  assign reg_write      = ctrl.reg_write;
  assign reg_dst        = ctrl.reg_dst;
  assign mem_to_reg     = ctrl.mem_to_reg;
  assign instr_done     = ctrl.instr_done;
  assign state          = reset ? '0 : ST_W'(state_q);
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal        = ctrl.illegal;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction state/strobe sequences,
// memory wait handling, mid-instruction reset and undefined-opcode handling.
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic        zero;
  logic        ir_write, pc_write, pc_write_cond, pc_source, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        reg_write, reg_dst, mem_to_reg, instr_done;
  logic [3:0]  state;
`ifdef MC_ILLEGAL_TRAP_EN
  logic        illegal;
`endif
  int unsigned checks = 0;
  int unsigned errors = 0;

  multicycle_control_if mem_if ();

  multicycle_control #(.OP_W(4), .ST_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .op            (op),
    .zero          (zero),
    .mem           (mem_if),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .instr_done    (instr_done),
    .state         (state)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .illegal       (illegal)
`endif
  );

  always #5 clock = ~clock;

  // {mem_req,mem_we,iord,ir_write,pc_write,pc_write_cond,pc_source,alu_src_a,alu_src_b,alu_op,reg_write,reg_dst,mem_to_reg,instr_done}
  logic [15:0] outs;
  assign outs = {mem_if.mem_req, mem_if.mem_we, mem_if.iord, ir_write, pc_write,
                 pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
                 reg_write, reg_dst, mem_to_reg, instr_done};

  localparam logic [15:0] V_FETCH  = 16'b10011000_01_00_0000;
  localparam logic [15:0] V_FETCHW = 16'b10000000_01_00_0000;
  localparam logic [15:0] V_DECODE = 16'b00000000_11_00_0000;
  localparam logic [15:0] V_NOP    = 16'b00000000_11_00_0001;
  localparam logic [15:0] V_EXR    = 16'b00000001_00_10_0000;
  localparam logic [15:0] V_WBR    = 16'b00000000_00_00_1101;
  localparam logic [15:0] V_EXI    = 16'b00000001_10_00_0000;
  localparam logic [15:0] V_WBI    = 16'b00000000_00_00_1001;
  localparam logic [15:0] V_MADDR  = 16'b00000001_10_00_0000;
  localparam logic [15:0] V_MRD    = 16'b10100000_00_00_0000;
  localparam logic [15:0] V_WBM    = 16'b00000000_00_00_1011;
  localparam logic [15:0] V_MWR    = 16'b11100000_00_00_0001;
  localparam logic [15:0] V_MWRW   = 16'b11100000_00_00_0000;
  localparam logic [15:0] V_BR     = 16'b00000111_00_01_0001;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; op = 4'b0000; zero = 1'b0; mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d expected 0", i, state); end
      checks++;
      if (outs !== 16'h0000) begin errors++; $display("FAIL reset_outs[%0d]: got %b expected %b", i, outs, 16'h0000); end
    end
    reset = 1'b0; #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_release_state: got %0d expected 0", state); end
    checks++;
    if (outs !== V_FETCH) begin errors++; $display("FAIL reset_release_outs: got %b expected %b", outs, V_FETCH); end
  endtask

  task automatic test_rtype();
    logic [3:0]  st [5];
    logic [15:0] vec [5];
    int unsigned dones = 0;
    st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    vec = '{V_FETCH, V_DECODE, V_EXR, V_WBR, V_FETCH};
    op = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      mem_if.mem_ready = 1'b1; #1;
      checks++;
      if (state !== st[i]) begin errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      checks++;
      if (outs !== vec[i]) begin errors++; $display("FAIL rtype_outs[%0d]: got %b expected %b", i, outs, vec[i]); end
      if (i < 4 && instr_done) dones++;
      if (i != 4) begin @(posedge clock); #1; end
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL rtype_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_addi_waits();
    logic [3:0]  st [6];
    logic [15:0] vec [6];
    logic        rdy [6];
    st  = '{4'd0, 4'd0, 4'd1, 4'd4, 4'd5, 4'd0};
    vec = '{V_FETCHW, V_FETCH, V_DECODE, V_EXI, V_WBI, V_FETCH};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    op = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      mem_if.mem_ready = rdy[i]; #1;
      checks++;
      if (state !== st[i]) begin errors++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      checks++;
      if (outs !== vec[i]) begin errors++; $display("FAIL addi_outs[%0d]: got %b expected %b", i, outs, vec[i]); end
      if (i != 5) begin @(posedge clock); #1; end
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [8];
    logic [15:0] vec [8];
    logic        rdy [8];
    st  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd7, 4'd7, 4'd8, 4'd0};
    vec = '{V_FETCH, V_DECODE, V_MADDR, V_MRD, V_MRD, V_MRD, V_WBM, V_FETCH};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    op = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      mem_if.mem_ready = rdy[i]; #1;
      checks++;
      if (state !== st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      checks++;
      if (outs !== vec[i]) begin errors++; $display("FAIL lw_outs[%0d]: got %b expected %b", i, outs, vec[i]); end
      if (i != 7) begin @(posedge clock); #1; end
    end
  endtask

  task automatic test_sw(input logic with_wait);
    logic [3:0]  st [6];
    logic [15:0] vec [6];
    logic        rdy [6];
    int unsigned n;
    int unsigned writes = 0;
    if (with_wait) begin
      st  = '{4'd0, 4'd1, 4'd6, 4'd9, 4'd9, 4'd0};
      vec = '{V_FETCH, V_DECODE, V_MADDR, V_MWRW, V_MWR, V_FETCH};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      n = 6;
    end else begin
      st  = '{4'd0, 4'd1, 4'd6, 4'd9, 4'd0, 4'd0};
      vec = '{V_FETCH, V_DECODE, V_MADDR, V_MWR, V_FETCH, V_FETCH};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      n = 5;
    end
    op = 4'b0110;
    for (int i = 0; i < int'(n); i++) begin
      mem_if.mem_ready = rdy[i]; #1;
      checks++;
      if (state !== st[i]) begin errors++; $display("FAIL sw%0d_state[%0d]: got %0d expected %0d", with_wait, i, state, st[i]); end
      checks++;
      if (outs !== vec[i]) begin errors++; $display("FAIL sw%0d_outs[%0d]: got %b expected %b", with_wait, i, outs, vec[i]); end
      if (reg_write) writes++;
      if (i != int'(n) - 1) begin @(posedge clock); #1; end
    end
    checks++;
    if (writes !== 0) begin errors++; $display("FAIL sw%0d_reg_write_count: got %0d expected 0", with_wait, writes); end
  endtask

  task automatic test_beq();
    logic [3:0]  st [4];
    logic [15:0] vec [4];
    st  = '{4'd0, 4'd1, 4'd10, 4'd0};
    vec = '{V_FETCH, V_DECODE, V_BR, V_FETCH};
    op = 4'b1000;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 4; i++) begin
        mem_if.mem_ready = 1'b1; #1;
        checks++;
        if (state !== st[i]) begin errors++; $display("FAIL beq_z%0d_state[%0d]: got %0d expected %0d", z, i, state, st[i]); end
        checks++;
        if (outs !== vec[i]) begin errors++; $display("FAIL beq_z%0d_outs[%0d]: got %b expected %b", z, i, outs, vec[i]); end
        if (i != 3) begin @(posedge clock); #1; end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] st [4];
    st = '{4'd0, 4'd1, 4'd6, 4'd7};
    op = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      mem_if.mem_ready = (i < 3); #1;
      checks++;
      if (state !== st[i]) begin errors++; $display("FAIL rstmid_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      if (i != 3) begin @(posedge clock); #1; end
    end
    reset = 1'b1; #1;
    checks++;
    if (outs !== 16'h0000 || state !== 4'd0) begin
      errors++; $display("FAIL rstmid_assert: got outs=%b state=%0d expected outs=0 state=0", outs, state);
    end
    @(posedge clock); #1;
    mem_if.mem_ready = 1'b1;
    reset = 1'b0; #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL rstmid_release_state: got %0d expected 0", state); end
    checks++;
    if (outs !== V_FETCH) begin errors++; $display("FAIL rstmid_release_outs: got %b expected %b", outs, V_FETCH); end
  endtask

`ifdef MC_ILLEGAL_TRAP_EN
  task automatic test_illegal();
    op = 4'b1111;
    mem_if.mem_ready = 1'b1; #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL ill_fetch_state: got %0d expected 0", state); end
    @(posedge clock); #1;
    checks++;
    if (state !== 4'd1 || outs !== V_DECODE) begin
      errors++; $display("FAIL ill_decode: got state=%0d outs=%b expected state=1 outs=%b", state, outs, V_DECODE);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      mem_if.mem_ready = i[0]; #1;
      checks++;
      if (state !== 4'd11 || illegal !== 1'b1 || outs !== 16'h0000) begin
        errors++; $display("FAIL ill_halt[%0d]: got state=%0d illegal=%b outs=%b expected state=11 illegal=1 outs=0", i, state, illegal, outs);
      end
    end
    reset = 1'b1; #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL ill_reset: got state=%0d illegal=%b expected 0 0", state, illegal); end
    @(posedge clock); #1;
    reset = 1'b0; mem_if.mem_ready = 1'b1; #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || outs !== V_FETCH) begin
      errors++; $display("FAIL ill_release: got state=%0d illegal=%b outs=%b expected 0 0 %b", state, illegal, outs, V_FETCH);
    end
  endtask
`else
  task automatic test_illegal();
    logic [3:0]  st [3];
    logic [15:0] vec [3];
    st  = '{4'd0, 4'd1, 4'd0};
    vec = '{V_FETCH, V_NOP, V_FETCH};
    op = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      mem_if.mem_ready = 1'b1; #1;
      checks++;
      if (state !== st[i]) begin errors++; $display("FAIL ill_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      checks++;
      if (outs !== vec[i]) begin errors++; $display("FAIL ill_outs[%0d]: got %b expected %b", i, outs, vec[i]); end
      if (i != 2) begin @(posedge clock); #1; end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_addi_waits();
    test_lw_wait();
    test_sw(1'b0);
    test_sw(1'b1);
    test_beq();
    test_reset_mid();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the 16-bit, 4-register MIPS-subset datapath (4-bit opcode in IR[15:12], rd in IR[7:6], rt in IR[9:8], imm8 in IR[7:0]).
- Replaces the single-cycle combinational main control.
- Sequences fetch/decode/execute/memory/writeback over a shared ALU and a single shared instruction/data memory port with a ready handshake.
- Emits per-cycle datapath strobes and mux selects.

Parameters:
- OP_W, 4, opcode width.
- ST_W, 4, state register width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- op  in  4  opcode from the instruction register, IR[15:12].
- zero  in  1  ALU zero flag; used in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, valid with mem_req.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_source  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- alu_src_a  out  1  ALU A source: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B source: 00 = register B, 01 = constant 2, 10 = sext(imm8), 11 = sext(imm8)<<1.
- alu_op  out  2  00 = add, 01 = sub, 10 = function from op[2:0].
- reg_write  out  1  register file write enable.
- reg_dst  out  1  write register: 1 = IR[7:6], 0 = IR[9:8].
- mem_to_reg  out  1  write data: 1 = memory data register, 0 = ALUOut.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- state  out  ST_W  current state, for debug.

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous, active-high, port `reset`.
- Reset:
  - While reset is sampled high, the next state is FETCH.
  - All outputs are forced to 0 during any cycle in which reset is high; state reads FETCH (4'h0).
  - Reset mid-instruction abandons the instruction with no further strobes.
- Outputs:
  - Outputs are decoded from the current state (Moore).
  - Exceptions: ir_write, pc_write and instr_done in wait states are gated by mem_ready, as stated per state.
  - Unlisted outputs are 0 in each state.
- FETCH (0): mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0.
  - If mem_ready: ir_write=1, pc_write=1 (PC+2), go to DECODE.
  - Otherwise hold FETCH, with no ir_write or pc_write.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on op:
  - 0000, 0001, 0010, 0011, 0111 go to EXEC_R.
  - 0100 goes to EXEC_I.
  - 0101 and 0110 go to MEM_ADDR.
  - 1000 goes to BRANCH.
  - Any other opcode: see Optional Feature.
- EXEC_R (2): alu_src_a=1, alu_src_b=00, alu_op=10; go to WB_R.
- WB_R (3): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; go to FETCH.
- EXEC_I (4): alu_src_a=1, alu_src_b=10, alu_op=00; go to WB_I.
- WB_I (5): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; go to FETCH.
- MEM_ADDR (6): alu_src_a=1, alu_src_b=10, alu_op=00. op 0101 goes to MEM_RD; op 0110 goes to MEM_WR.
- MEM_RD (7): mem_req=1, iord=1. Wait for mem_ready, then go to WB_MEM.
- WB_MEM (8): reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; go to FETCH.
- MEM_WR (9): mem_req=1, mem_we=1, iord=1.
  - If mem_ready: instr_done=1, go to FETCH.
  - Otherwise hold.
- BRANCH (10): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, instr_done=1; go to FETCH.
- Cycle counts with zero-wait memory:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Each wait cycle adds 1.
- Handshake rules:
  - mem_req stays high and mem_we and iord stay stable until mem_ready is sampled high.
  - mem_ready outside a request state is ignored.
- Unused state encodings go to FETCH on the next cycle, with all outputs 0.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in DECODE goes to HALT (11).
  - HALT drives all strobes 0 and adds output illegal (1 bit), which is 1 only in HALT.
  - HALT is left only by reset.
- Undefined:
  - An undefined opcode in DECODE asserts instr_done=1 and goes to FETCH (NOP, 2 cycles).
  - No illegal port exists.

Decomposition:
- Package mc_pkg holds:
  - State encodings (FETCH=0 … HALT=11).
  - Opcode constants (OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_ADDI=0100, OP_LW=0101, OP_SW=0110, OP_SLT=0111, OP_BEQ=1000).
  - ALUSrcB and ALUOp encodings.
- One sub-module: mc_output_decode, a pure decode from state plus mem_ready to the output strobes.
- The top level holds the state register and next-state logic.

Test Plan:
- Reset held 3 cycles with mem_ready=1 → all outputs 0, state=0. After release, first cycle: mem_req=1, ir_write=1, pc_write=1.
- op=0000, mem_ready=1 → states 0,1,2,3,0. reg_write=1 and reg_dst=1 only in state 3. instr_done pulses once, 4 cycles after the fetch began.
- op=0101, mem_ready low for 2 cycles in MEM_RD → states 0,1,6,7,7,7,8,0. mem_req=1 and iord=1 for all 3 MEM_RD cycles. WB_MEM has mem_to_reg=1.
- op=0110, mem_ready=1 → states 0,1,6,9,0. mem_we=1 only in state 9, with instr_done=1 in that same cycle. reg_write is never 1.
- op=1000, zero=1 then repeated with zero=0 → BRANCH asserts pc_write_cond=1, pc_source=1, alu_op=01 in both runs. Both return to FETCH after 3 cycles.
- op=1111 → without the macro: state 1 → 0 with instr_done=1. With MC_ILLEGAL_TRAP_EN: state 11 with illegal=1 held for 10 cycles; reset returns state to 0.
